multi_run_tracker: RTL
======================

MULTI_RUN_TRACKER -- requirements
Module: multi_run_tracker

Parameters
REQ-001 NUM_RUNS, 4, number of concurrent run channels (1..8).
REQ-002 HR_W, 8, heart-rate sample width (bpm, unsigned).
REQ-003 SPS_W, 2, steps-per-sample width (unsigned).
REQ-004 STEP_W, 16, per-run step accumulator width.
REQ-005 CNT_W, 8, per-run sample counter width.

Interface
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  pulse; begins a session.
REQ-009 stop  in  1  pulse; ends accumulation, begins report.
REQ-010 sample_valid  in  NUM_RUNS  per-run sample qualifier.
REQ-011 hr_in  in  NUM_RUNS*HR_W  packed HR samples, run i at [i*HR_W +: HR_W].
REQ-012 sps_in  in  NUM_RUNS*SPS_W  packed steps samples, same packing.
REQ-013 busy  out  1  high in ACTIVE or REPORT.
REQ-014 report_valid  out  1  report record available.
REQ-015 report_ready  in  1  consumer accepts record.
REQ-016 report_idx  out  3  run index of current record.
REQ-017 report_steps  out  STEP_W  total steps of run.
REQ-018 report_max_hr  out  HR_W  maximum HR of run.
REQ-019 report_avg_hr  out  HR_W  floor(hr_sum/sample_count) of run.
REQ-020 report_hr_cmp  out  2  avg vs run 0: 01 higher, 10 lower, 00 same.
REQ-021 report_step_ok  out  1  1 when run steps >= run 0 steps.
REQ-022 done  out  1  one-cycle pulse after last record accepted.

Function
REQ-023 FSM states IDLE, ACTIVE, REPORT; reset state IDLE.
REQ-024 IDLE: start=1 -> ACTIVE next cycle; all per-run accumulators (steps, hr_sum, count, max_hr) cleared on that edge.
REQ-025 ACTIVE: for each i with sample_valid[i]=1: steps_i += sps_i, hr_sum_i += hr_i, count_i += 1, max_hr_i = max(max_hr_i, hr_i); runs update independently in the same cycle.
REQ-026 steps_i and count_i saturate at all-ones; a saturated count freezes hr_sum_i for that run; hr_sum width HR_W+CNT_W.
REQ-027 ACTIVE: stop=1 -> REPORT; samples valid on the stop cycle are accumulated; start ignored in ACTIVE; start+stop same cycle -> stop wins.
REQ-028 stop in IDLE, and start/stop/sample_valid in REPORT, are ignored.
REQ-029 REPORT: report_valid=1 from first REPORT cycle; report_idx starts at 0; fields reflect run report_idx and are held stable while report_valid && !report_ready.
REQ-030 Handshake: record transfers when report_valid && report_ready; idx increments; after idx NUM_RUNS-1 transfers -> IDLE, done=1 for exactly that next cycle.
REQ-031 count_i=0 -> report_avg_hr=0 and report_max_hr=0.
REQ-032 Run 0 record always reports report_hr_cmp=00, report_step_ok=1.
REQ-033 Comparison uses averaged HR, unsigned; equality -> 00.
REQ-034 Every output other than the report fields is registered.

Reset
REQ-035 rst=1 mid-session (ACTIVE or REPORT) returns to IDLE on the next edge and discards all accumulation; rst has priority over all inputs.
REQ-036 Reset values: busy=0, report_valid=0, report_idx=0, done=0, all report fields 0, all accumulators 0.

Verification (NUM_RUNS=2 unless stated)
REQ-037 start; 5 samples run0 HR 121,132,143,154,165 sps 2 each; run1 HR 96,104,112,120,128 sps 3 each; stop; ready=1 -> rec0 steps 10 max 165 avg 143 cmp 00 ok 1; rec1 steps 15 max 128 avg 112 cmp 10 ok 1; done pulses once.
REQ-038 Backpressure: ready=0 for 4 cycles in REPORT -> rec0 held unchanged, idx 0; ready=1 -> rec0 then rec1 transfer on consecutive cycles.
REQ-039 Run1 never valid -> rec1 steps 0, avg 0, max 0, cmp 10, ok 0 (run 0 nonzero).
REQ-040 STEP_W=4: 6 samples of sps 3 on run0 -> steps 15 (saturated).
REQ-041 rst asserted in ACTIVE after 3 samples -> busy=0 next cycle; new session reports only post-reset samples.
REQ-042 start+stop together in ACTIVE -> enters REPORT; stop in IDLE -> no state change, report_valid stays 0.

Source files
------------

// File: rtl/multi_run_tracker.sv
// multi_run_tracker
//   Tracks NUM_RUNS concurrent runs during a session (steps, HR sum, sample
//   count, max HR). When the session stops, it reports one record per run
//   over a valid/ready handshake.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start, stop            session control pulses
//   sample_valid[NUM_RUNS] per-run sample qualifier
//   hr_in, sps_in          packed per-run samples, run i at [i*W +: W]
//   busy                   session in progress (ACTIVE or REPORT)
//   report_*               current record for run report_idx; handshake via report_ready
//   done                   one-cycle pulse after the last record is accepted

// Per-run accumulator: saturating steps/count, HR sum, max HR, floor average.
module multi_run_tracker_run #(
    parameter int HR_W   = 8,
    parameter int SPS_W  = 2,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [HR_W-1:0]   hr,
    input  logic [SPS_W-1:0]  sps,
    output logic [STEP_W-1:0] steps,
    output logic [HR_W-1:0]   max_hr,
    output logic [HR_W-1:0]   avg_hr
);
    localparam int SUM_W = HR_W + CNT_W;

    logic [SUM_W-1:0]  hr_sum;
    logic [CNT_W-1:0]  count;
    logic [STEP_W:0]   steps_ext;
    logic [SUM_W-1:0]  quot;

    // The extra bit is the carry out of the step add, used for saturation.
    assign steps_ext = {1'b0, steps} + (STEP_W+1)'(sps);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            steps  <= '0;
            max_hr <= '0;
            hr_sum <= '0;
            count  <= '0;
        end else if (upd) begin
            steps <= steps_ext[STEP_W] ? '1 : steps_ext[STEP_W-1:0];
            // A saturated count freezes the sum, so the average stays the
            // average of the first 2^CNT_W-1 samples. The sum cannot overflow.
            if (count != '1) begin
                count  <= count + 1'b1;
                hr_sum <= hr_sum + SUM_W'(hr);
            end
            if (hr > max_hr) max_hr <= hr;
        end
    end

    // The quotient never exceeds the largest sample, so it fits in HR_W bits.
    always_comb begin
        quot = '0;
        if (count != '0) quot = hr_sum / SUM_W'(count);
        avg_hr = quot[HR_W-1:0];
    end
endmodule

module multi_run_tracker #(
    parameter int NUM_RUNS = 4,
    parameter int HR_W     = 8,
    parameter int SPS_W    = 2,
    parameter int STEP_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [NUM_RUNS-1:0]       sample_valid,
    input  logic [NUM_RUNS*HR_W-1:0]  hr_in,
    input  logic [NUM_RUNS*SPS_W-1:0] sps_in,
    output logic                      busy,
    output logic                      report_valid,
    input  logic                      report_ready,
    output logic [2:0]                report_idx,
    output logic [STEP_W-1:0]         report_steps,
    output logic [HR_W-1:0]           report_max_hr,
    output logic [HR_W-1:0]           report_avg_hr,
    output logic [1:0]                report_hr_cmp,
    output logic                      report_step_ok,
    output logic                      done
);
    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

    state_t state, state_nxt;

    logic [NUM_RUNS-1:0][STEP_W-1:0] steps;
    logic [NUM_RUNS-1:0][HR_W-1:0]   max_hr;
    logic [NUM_RUNS-1:0][HR_W-1:0]   avg_hr;

    logic clr;
    logic xfer;
    logic last;

    assign clr  = (state == IDLE) && start;
    assign xfer = (state == REPORT) && report_valid && report_ready;
    assign last = (report_idx == 3'(NUM_RUNS-1));

    genvar g;
    generate
        for (g = 0; g < NUM_RUNS; g++) begin : g_run
            multi_run_tracker_run #(
                .HR_W(HR_W), .SPS_W(SPS_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
            ) u_run (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .upd    ((state == ACTIVE) && sample_valid[g]),
                .hr     (hr_in[g*HR_W +: HR_W]),
                .sps    (sps_in[g*SPS_W +: SPS_W]),
                .steps  (steps[g]),
                .max_hr (max_hr[g]),
                .avg_hr (avg_hr[g])
            );
        end
    endgenerate

    // Next state. Stop wins over start while ACTIVE. REPORT ignores the
    // session controls and only moves on the handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACTIVE;
            ACTIVE:  if (stop)  state_nxt = REPORT;
            REPORT:  if (xfer && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are registered from the next state, so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            report_valid <= (state_nxt == REPORT);
            done         <= xfer && last;
            if (xfer) report_idx <= last ? 3'd0 : report_idx + 3'd1;
            else if (state != REPORT) report_idx <= '0;
        end
    end

    // Record fields are combinational from the selected run. They are forced
    // to zero outside REPORT.
    logic [STEP_W-1:0] sel_steps;
    logic [HR_W-1:0]   sel_max, sel_avg;

    always_comb begin
        sel_steps = steps[0];
        sel_max   = max_hr[0];
        sel_avg   = avg_hr[0];
        for (int i = 1; i < NUM_RUNS; i++) begin
            if (report_idx == 3'(i)) begin
                sel_steps = steps[i];
                sel_max   = max_hr[i];
                sel_avg   = avg_hr[i];
            end
        end
    end

    always_comb begin
        report_steps   = '0;
        report_max_hr  = '0;
        report_avg_hr  = '0;
        report_hr_cmp  = 2'b00;
        report_step_ok = 1'b0;
        if (report_valid) begin
            report_steps   = sel_steps;
            report_max_hr  = sel_max;
            report_avg_hr  = sel_avg;
            report_step_ok = 1'b1;
            if (report_idx != 3'd0) begin
                if (sel_avg > avg_hr[0])      report_hr_cmp = 2'b01;
                else if (sel_avg < avg_hr[0]) report_hr_cmp = 2'b10;
                report_step_ok = (sel_steps >= steps[0]);
            end
        end
    end
endmodule
